conv1d_obi_mgr_port: RTL and testbench
======================================

Name: conv1d_obi_mgr_port

Overview:
- OBI manager port for the conv1d accelerator: the initiator-side counterpart of the subordinate OBI-to-SRAM shim on the accelerator's buffer port.
- Converts the accelerator's simple SRAM-style request (req/we/addr/wdata/be, gnt) into an OBI manager transaction on the croc system bus, so conv1d can fetch inputs and write results in main memory directly.
- Tracks up to MaxOutstanding in-flight transactions and returns responses in order, with a registered response path.

Parameters:
- MaxOutstanding, 2: maximum OBI transactions granted but not yet answered (1..8).
- AddrWidth, 32: local and OBI address width.
- DataWidth, 32: data width; be width is DataWidth/8.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- req_i  input  1  local request valid.
- we_i  input  1  local write enable (1 = write).
- addr_i  input  AddrWidth  local byte address.
- wdata_i  input  DataWidth  local write data.
- be_i  input  DataWidth/8  local byte enables.
- gnt_o  output  1  local grant; the request is accepted in a cycle where req_i and gnt_o are both high.
- rvalid_o  output  1  local response valid; one-cycle pulse per accepted request.
- rdata_o  output  DataWidth  read data; zero for writes.
- err_o  output  1  response error; qualified by rvalid_o.
- idle_o  output  1  high when the outstanding count is 0 and no local request is pending.
- obi_req_o  output  mgr_obi_req_t  OBI manager request: a.req, a.addr, a.we, a.be, a.wdata, a.aid = 0.
- obi_rsp_i  input  mgr_obi_rsp_t  OBI response: gnt, rvalid, r.rdata, r.err.

Behaviour:
- Reset values: obi a.req=0, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, idle_o=1, outstanding count=0, address FIFO empty.
- credit_ok = (outstanding count < MaxOutstanding).
- A channel:
  - a.req = req_i & credit_ok.
  - a.addr/we/be/wdata pass through combinationally from the local inputs.
  - gnt_o = obi gnt & a.req.
- Local requester contract: hold req_i and its payload stable until gnt_o.
- OBI stability: the count only decreases while a request waits for gnt, so a.req never drops before gnt.
- Handshake (hs) = a.req & gnt.
- Outstanding count:
  - hs only: +1.
  - obi rvalid only: -1.
  - hs and obi rvalid in the same cycle: unchanged.
- At count == MaxOutstanding: a.req forced low and gnt_o low until an rvalid frees a slot. Same-cycle reuse is not allowed; the freed slot is usable from the next cycle.
- Response path is registered, latency 1: obi rvalid in cycle N gives rvalid_o, rdata_o and err_o in cycle N+1.
  - rdata_o is forced to 0 when the matching request was a write.
  - A we-flag FIFO (depth MaxOutstanding) records we_i at each hs and is popped on each obi rvalid.
  - When no rvalid arrives, rvalid_o=0 and rdata_o/err_o hold their previous values.
- Ordering: OBI is in-order; the FIFO head always matches the oldest outstanding request.
- Back-to-back: grant in consecutive cycles while credit_ok holds; sustained throughput is 1 transaction per cycle when MaxOutstanding >= bus latency + 1.
- Spurious obi rvalid while the count is 0:
  - ignored; no counter underflow, no FIFO pop, rvalid_o not raised.
  - An assertion flags it in simulation.
- Reset mid-operation: the count and FIFOs clear immediately. Responses to pre-reset requests arrive with count 0 and are dropped per the spurious rule.
- idle_o = (count == 0) & ~req_i, registered on the count (count term) and combinational on req_i.

Optional Feature:
- Macro: CONV1D_OBI_MGR_ERR_LOG_EN.
- Defined:
  - Adds outputs err_cnt_o (8 bits, saturating at 255) and err_addr_o (AddrWidth), plus input err_clr_i (1).
  - An address FIFO (depth MaxOutstanding) records addr_i at each hs and pops on obi rvalid.
  - On rvalid with r.err=1: err_cnt_o increments and err_addr_o captures the popped address, both in the same cycle as rvalid_o.
  - err_clr_i=1 zeroes both outputs next cycle; if an error arrives in the same cycle, clear wins.
  - Both outputs reset to 0.
- Undefined: the ports and the address FIFO are absent; all other behaviour is identical.

Test Plan:
- Single read: addr_i=0x1000_0040, bus gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> gnt_o in cycle 0, rvalid_o=1 with rdata_o=0xDEADBEEF, err_o=0 in cycle 3.
- Credit limit, MaxOutstanding=2: three back-to-back reads with gnt always high and rvalid held off -> first two granted, a.req=0 for the third until the first rvalid, third granted the cycle after it, count never exceeds 2.
- Simultaneous handshake and rvalid at count=1 -> count stays 1; the FIFO pushes the new we and pops the old in order.
- Mixed write/read: write 0x1234_5678 with be=4'b0011, then read returning 0xCAFEF00D -> first rvalid_o has rdata_o=0, second has rdata_o=0xCAFEF00D.
- Error response: r.err=1 on a read of 0x2000_0000 -> err_o=1 with rvalid_o. With CONV1D_OBI_MGR_ERR_LOG_EN: err_cnt_o=1 and err_addr_o=0x2000_0000; err_clr_i -> both 0 next cycle.
- Reset with 2 outstanding, then 2 late rvalids -> no rvalid_o pulses, count stays 0, idle_o=1, spurious-rvalid assertion fires.

Source files
------------

// File: rtl/conv1d_obi_mgr_port.sv
// OBI manager port for conv1d: SRAM-style local requests become in-order OBI transactions with credit tracking.
// Optional error logging (err_cnt_o/err_addr_o/err_clr_i) is enabled by defining CONV1D_OBI_MGR_ERR_LOG_EN.

package conv1d_obi_mgr_pkg;
    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;

    typedef struct packed {
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
        logic                      aid;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        mgr_obi_a_chan_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic                    err;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;
endpackage

module conv1d_obi_mgr_port
    import conv1d_obi_mgr_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = ObiAddrWidth,
    parameter int unsigned DataWidth      = ObiDataWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    output logic                   idle_o,
`ifdef CONV1D_OBI_MGR_ERR_LOG_EN
    input  logic                   err_clr_i,
    output logic [7:0]             err_cnt_o,
    output logic [AddrWidth-1:0]   err_addr_o,
`endif
    output mgr_obi_req_t           obi_req_o,
    input  mgr_obi_rsp_t           obi_rsp_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic            we_fifo_q [MaxOutstanding];
    logic            credit_ok, a_req, hs, rsp_ok;

    logic                 rsp_vld_p1;
    logic [DataWidth-1:0] rdata_p1;
    logic                 err_p1;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign credit_ok = cnt_q < CntW'(MaxOutstanding);
    assign a_req     = req_i & credit_ok;
    assign hs        = a_req & obi_rsp_i.gnt;
    // A response with nothing outstanding (e.g. one issued before a reset) is dropped.
    assign rsp_ok    = obi_rsp_i.rvalid & (cnt_q != '0);

    assign gnt_o  = hs;
    assign idle_o = (cnt_q == '0) & ~req_i;

    always_comb begin
        obi_req_o         = '0;
        obi_req_o.req     = a_req;
        obi_req_o.a.addr  = ObiAddrWidth'(addr_i);
        obi_req_o.a.we    = we_i;
        obi_req_o.a.be    = (ObiDataWidth/8)'(be_i);
        obi_req_o.a.wdata = ObiDataWidth'(wdata_i);
        obi_req_o.a.aid   = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hs && !rsp_ok) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (rsp_ok && !hs) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (hs) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (rsp_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (hs) begin
            we_fifo_q[wr_ptr_q] <= we_i;
        end
    end

    // ---- response stage p1: one cycle after OBI rvalid ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_p1 <= 1'b0;
            rdata_p1   <= '0;
            err_p1     <= 1'b0;
        end else begin
            rsp_vld_p1 <= rsp_ok;
            if (rsp_ok) begin
                rdata_p1 <= we_fifo_q[rd_ptr_q] ? '0 : DataWidth'(obi_rsp_i.r.rdata);
                err_p1   <= obi_rsp_i.r.err;
            end
        end
    end

    assign rvalid_o = rsp_vld_p1;
    assign rdata_o  = rdata_p1;
    assign err_o    = err_p1;

`ifdef CONV1D_OBI_MGR_ERR_LOG_EN
    logic [AddrWidth-1:0] addr_fifo_q [MaxOutstanding];
    logic [7:0]           err_cnt_p1;
    logic [AddrWidth-1:0] err_addr_p1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (hs) begin
            addr_fifo_q[wr_ptr_q] <= addr_i;
        end
    end

    // Clear takes priority over an error arriving in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_p1  <= '0;
            err_addr_p1 <= '0;
        end else if (err_clr_i) begin
            err_cnt_p1  <= '0;
            err_addr_p1 <= '0;
        end else if (rsp_ok && obi_rsp_i.r.err) begin
            err_cnt_p1  <= sat_inc8(err_cnt_p1);
            err_addr_p1 <= addr_fifo_q[rd_ptr_q];
        end
    end

    assign err_cnt_o  = err_cnt_p1;
    assign err_addr_o = err_addr_p1;
`endif

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(obi_rsp_i.rvalid && (cnt_q == '0)))
            else $warning("conv1d_obi_mgr_port: OBI rvalid with no outstanding request, dropped");
        end
    end
`endif

endmodule

// File: tb/tb_conv1d_obi_mgr_port.sv
// Bench for conv1d_obi_mgr_port: queue-based reference model checked every cycle plus directed literal checks.
// Also covers the CONV1D_OBI_MGR_ERR_LOG_EN outputs when that macro is defined.

module tb_conv1d_obi_mgr_port;
    import conv1d_obi_mgr_pkg::*;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        gnt_o, rvalid_o, err_o, idle_o;
    logic [31:0] rdata_o;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;
    mgr_obi_req_t obi_req;
    mgr_obi_rsp_t obi_rsp;
`ifdef CONV1D_OBI_MGR_ERR_LOG_EN
    logic        err_clr = 1'b0;
    logic [7:0]  err_cnt;
    logic [31:0] err_addr;
`endif

    assign obi_rsp = '{gnt: bus_gnt, rvalid: bus_rvalid, r: '{rdata: bus_rdata, err: bus_err}};

    conv1d_obi_mgr_port #(.MaxOutstanding(MAXO), .AddrWidth(32), .DataWidth(32)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .be_i      (be_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .idle_o    (idle_o),
`ifdef CONV1D_OBI_MGR_ERR_LOG_EN
        .err_clr_i (err_clr),
        .err_cnt_o (err_cnt),
        .err_addr_o(err_addr),
`endif
        .obi_req_o (obi_req),
        .obi_rsp_i (obi_rsp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding requests are a queue of (we, addr); responses retire from the front.
    bit          we_q[$];
    logic [31:0] addr_q[$];
    logic        exp_rv = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic [7:0]  exp_ecnt = '0;
    logic [31:0] exp_eaddr = '0;

    always @(negedge clk) begin
        logic        exp_areq;
        logic        rsp;
        logic        hs;
        bit          w;
        logic [31:0] a;
        if (!rst_n) begin
            we_q.delete();
            addr_q.delete();
            exp_rv    = 1'b0;
            exp_rdata = '0;
            exp_err   = 1'b0;
            exp_ecnt  = '0;
            exp_eaddr = '0;
        end
        exp_areq = req_i && (we_q.size() < MAXO);
        chk("a_req",   obi_req.req, exp_areq);
        chk("gnt",     gnt_o, exp_areq && bus_gnt);
        chk("idle",    idle_o, (we_q.size() == 0) && !req_i);
        chk("a_addr",  obi_req.a.addr, addr_i);
        chk("a_we",    obi_req.a.we, we_i);
        chk("a_be",    obi_req.a.be, be_i);
        chk("a_wdata", obi_req.a.wdata, wdata_i);
        chk("a_aid",   obi_req.a.aid, 0);
        chk("rvalid",  rvalid_o, exp_rv);
        chk("rdata",   rdata_o, exp_rdata);
        chk("err",     err_o, exp_err);
`ifdef CONV1D_OBI_MGR_ERR_LOG_EN
        chk("err_cnt",  err_cnt, exp_ecnt);
        chk("err_addr", err_addr, exp_eaddr);
`endif
        if (rst_n) begin
            rsp    = bus_rvalid && (we_q.size() > 0);
            hs     = exp_areq && bus_gnt;
            exp_rv = rsp;
            a      = '0;
            if (rsp) begin
                w         = we_q.pop_front();
                a         = addr_q.pop_front();
                exp_rdata = w ? 32'h0 : bus_rdata;
                exp_err   = bus_err;
            end
`ifdef CONV1D_OBI_MGR_ERR_LOG_EN
            if (err_clr) begin
                exp_ecnt  = '0;
                exp_eaddr = '0;
            end else if (rsp && bus_err) begin
                exp_ecnt  = (exp_ecnt == 8'hFF) ? exp_ecnt : exp_ecnt + 8'd1;
                exp_eaddr = a;
            end
`endif
            if (hs) begin
                we_q.push_back(we_i);
                addr_q.push_back(addr_i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] gpat;
        logic [15:0] rpat;
        logic        g;
        int          n;

        // reset state
        @(negedge clk);
        chk("rst_idle", idle_o, 1);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_areq", obi_req.req, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single read, bus grants at once, rvalid two cycles later
        req_i = 1; we_i = 0; addr_i = 32'h1000_0040; be_i = 4'hF; bus_gnt = 1;
        @(negedge clk); chk("t1_gnt", gnt_o, 1);
        tick; req_i = 0; bus_gnt = 0;
        tick; bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF;
        tick; bus_rvalid = 0;
        @(negedge clk);
        chk("t1_rvalid", rvalid_o, 1);
        chk("t1_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("t1_err", err_o, 0);
        tick;
        @(negedge clk); chk("t1_rvalid_end", rvalid_o, 0); chk("t1_idle", idle_o, 1);

        // credit limit: third read waits for the first response
        tick; req_i = 1; addr_i = 32'h100; bus_gnt = 1;
        @(negedge clk); chk("t2_gnt0", gnt_o, 1);
        tick; addr_i = 32'h104;
        @(negedge clk); chk("t2_gnt1", gnt_o, 1);
        tick; addr_i = 32'h108;
        @(negedge clk); chk("t2_gnt2", gnt_o, 0); chk("t2_areq2", obi_req.req, 0);
        tick;
        @(negedge clk); chk("t2_gnt3", gnt_o, 0);
        tick; bus_rvalid = 1; bus_rdata = 32'hA0;
        @(negedge clk); chk("t2_noreuse", gnt_o, 0);
        tick; bus_rvalid = 0;
        @(negedge clk); chk("t2_gnt_after", gnt_o, 1); chk("t2_rdata0", rdata_o, 32'hA0);
        tick; req_i = 0; bus_rvalid = 1; bus_rdata = 32'hA1;
        tick; bus_rdata = 32'hA2;
        tick; bus_rvalid = 0;
        @(negedge clk); chk("t2_rdata2", rdata_o, 32'hA2); chk("t2_idle", idle_o, 1);

        // write then read; read handshake coincides with the write's rvalid
        tick; req_i = 1; we_i = 1; addr_i = 32'h200; wdata_i = 32'h1234_5678; be_i = 4'b0011; bus_gnt = 1;
        @(negedge clk);
        chk("t3_wdata", obi_req.a.wdata, 32'h1234_5678);
        chk("t3_be", obi_req.a.be, 4'b0011);
        chk("t3_we", obi_req.a.we, 1);
        tick; we_i = 0; addr_i = 32'h204; be_i = 4'hF; bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk); chk("t3_gnt_sim", gnt_o, 1);
        tick; req_i = 0; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("t3_wr_rvalid", rvalid_o, 1);
        chk("t3_wr_rdata", rdata_o, 0);
        chk("t3_busy", idle_o, 0);
        tick; bus_rvalid = 0;
        @(negedge clk); chk("t3_rd_rdata", rdata_o, 32'hCAFE_F00D); chk("t3_idle", idle_o, 1);

        // error response
        tick; req_i = 1; addr_i = 32'h2000_0000;
        tick; req_i = 0; bus_gnt = 0; bus_rvalid = 1; bus_err = 1; bus_rdata = 0;
        tick; bus_rvalid = 0; bus_err = 0;
        @(negedge clk);
        chk("t4_rvalid", rvalid_o, 1);
        chk("t4_err", err_o, 1);
`ifdef CONV1D_OBI_MGR_ERR_LOG_EN
        chk("t4_err_cnt", err_cnt, 1);
        chk("t4_err_addr", err_addr, 32'h2000_0000);
        err_clr = 1;
        tick; err_clr = 0;
        @(negedge clk); chk("t4_clr_cnt", err_cnt, 0); chk("t4_clr_addr", err_addr, 0);
`endif

        // back-to-back traffic with irregular grant/response patterns
        gpat = 16'b1011_0111_1101_1110;
        rpat = 16'b1101_1011_0111_0110;
        tick; req_i = 1; we_i = 0; addr_i = 32'h400; wdata_i = 32'h0;
        for (int i = 0; i < 16; i++) begin
            bus_gnt    = gpat[i];
            bus_rvalid = rpat[i] && (we_q.size() > 0);
            bus_rdata  = 32'h0101_0101 * (i + 1);
            bus_err    = (i == 7);
            @(negedge clk); g = gnt_o;
            tick;
            if (g) begin
                addr_i  = addr_i + 32'd4;
                we_i    = ~we_i;
                wdata_i = wdata_i + 32'd1;
            end
        end
        req_i = 0; bus_gnt = 0; bus_err = 0;
        n = 0;
        while (we_q.size() > 0 && n < 8) begin
            bus_rvalid = 1;
            tick;
            n++;
        end
        bus_rvalid = 0;
        chk("t5_drained", we_q.size(), 0);
        tick;

        // reset with two outstanding, then two late responses are dropped
        req_i = 1; we_i = 0; addr_i = 32'h300; bus_gnt = 1;
        tick; addr_i = 32'h304;
        tick; req_i = 0; bus_gnt = 0;
        @(negedge clk); chk("t6_busy", idle_o, 0);
        tick; rst_n = 0;
        @(negedge clk); chk("t6_rst_idle", idle_o, 1); chk("t6_rst_rvalid", rvalid_o, 0);
        tick; rst_n = 1; bus_rvalid = 1; bus_rdata = 32'h55;
        tick;
        @(negedge clk); chk("t6_drop0", rvalid_o, 0); chk("t6_idle0", idle_o, 1);
        tick; bus_rvalid = 0;
        @(negedge clk); chk("t6_drop1", rvalid_o, 0); chk("t6_idle1", idle_o, 1);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
